// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the RAM port arbiter.
//   arb_state_e  : arbiter FSM state (IDLE = free round-robin, LOCKED = burst owner holds port)
//   idx_width()  : bits needed to index NUM_REQ requesters (minimum 1)
//   wstrb_width(): byte-lane count for a data width / lane width pair
package ram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned wstrb_width(input int unsigned dw, input int unsigned bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
//   valid     : per-requester request lines
//   prio_ptr  : requester index that has highest priority this cycle
//   grant     : one-hot winner (all zero when nothing is valid)
//   grant_idx : binary index of the winner
//   any_valid : at least one requester is valid
module rr_priority_pick
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   prio_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    int unsigned          pos;

    always_comb begin
        // Rotating the doubled vector puts prio_ptr at bit 0; the first set bit is the winner.
        valid_dbl = {valid, valid};
        valid_rot = NUM_REQ'(valid_dbl >> prio_ptr);
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        pos       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && valid_rot[k]) begin
                any_valid = 1'b1;
                pos       = k + 32'(prio_ptr);
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                grant_idx = pos[IDX_W-1:0];
            end
        end
        if (any_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-lane RAM port among NUM_REQ requesters.
// Round-robin grant with burst lock (req_last releases), combinational RAM drive from the granted
// beat, and a registered one-hot tag that routes the 1-cycle-late read data to its issuer.
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/ready/we/last   : per-requester beat handshake and attributes
//   req_addr/wdata/wstrb      : per-requester beat payload, flattened (requester i at slice i)
//   rsp_valid, rsp_rdata      : one-hot read response and shared read data
//   ram_addr/wdata/write_en   : RAM command port
//   ram_rdata                 : RAM read data, valid one cycle after the address
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned WSTRB_W    = wstrb_width(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*WSTRB_W-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    output logic [WSTRB_W-1:0]            ram_write_en,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      prio_ptr_q, prio_ptr_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  granted;
    logic [IDX_W-1:0]      next_ptr;

    logic                  sel_we;
    logic                  sel_last;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [WSTRB_W-1:0]    sel_wstrb;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid     (req_valid),
        .prio_ptr  (prio_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // Grant: free pick when idle, owner only when locked; nothing while reset is asserted.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        granted   = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                grant     = pick_grant;
                grant_idx = pick_idx;
                granted   = pick_any;
            end else if (req_valid[owner_q]) begin
                grant[owner_q] = 1'b1;
                grant_idx      = owner_q;
                granted        = 1'b1;
            end
        end
        next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Payload of the granted beat; all zero when nothing is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_last  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_last  = req_last[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = req_wstrb[i*WSTRB_W +: WSTRB_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_ptr_d = prio_ptr_q;
        if (granted) begin
            if (sel_last) begin
                state_d    = IDLE;
                prio_ptr_d = next_ptr;
            end else begin
                state_d = LOCKED;
                owner_d = grant_idx;
            end
        end
        rsp_valid_d  = (granted && !sel_we) ? grant : '0;
        // Keep the last returned word so rsp_rdata holds between responses.
        rdata_hold_d = (|rsp_valid_q) ? ram_rdata : rdata_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            prio_ptr_q   <= '0;
            rsp_valid_q  <= '0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            prio_ptr_q   <= prio_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign req_ready    = grant;
    assign ram_addr     = sel_addr;
    assign ram_wdata    = sel_we ? sel_wdata : '0;
    assign ram_write_en = sel_we ? sel_wstrb : '0;
    assign rsp_valid    = rsp_valid_q;
    // RAM data arrives one cycle after the address, i.e. in the same cycle as the tag.
    assign rsp_rdata    = (|rsp_valid_q) ? ram_rdata : rdata_hold_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a read-response scoreboard.
module tb_ram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid, req_ready, req_we, req_last, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_wstrb;
    logic [DW-1:0]  rsp_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0]  ram_addr;
    logic [SW-1:0]  ram_write_en;

    // Per-requester stimulus
    logic [AW-1:0]  s_addr  [NR];
    logic [DW-1:0]  s_wdata [NR];
    logic [SW-1:0]  s_wstrb [NR];

    logic [DW-1:0]  mem     [256];
    logic [DW-1:0]  exp_mem [256];

    typedef struct packed {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_last     (req_last),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_write_en (ram_write_en),
        .ram_rdata    (ram_rdata)
    );

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = s_addr[i];
            req_wdata[i*DW +: DW] = s_wdata[i];
            req_wstrb[i*SW +: SW] = s_wstrb[i];
        end
    end

    // Synchronous RAM: data for the address of cycle N appears in cycle N+1.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[7:0]];
        for (int l = 0; l < SW; l++) begin
            if (ram_write_en[l]) mem[ram_addr[7:0]][l*8 +: 8] = ram_wdata[l*8 +: 8];
        end
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0101;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) begin
            s_addr[i]  = '0;
            s_wdata[i] = '0;
            s_wstrb[i] = '0;
        end
    endtask

    task automatic sb_restart();
        sb.delete();
        sb.push_back('0);
    endtask

    // One cycle: check grant and RAM drive mid-cycle, check the response due this cycle,
    // queue the response due next cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [NR-1:0] exp_rdy);
        int            g;
        logic [SW-1:0] ew;
        rsp_t          e;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
        g  = -1;
        ew = '0;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) g = i;
        if (g >= 0 && req_we[g]) ew = s_wstrb[g];
        chk({tag, "_wen"}, 64'(ram_write_en), 64'(ew));
        if (g >= 0) chk({tag, "_addr"}, 64'(ram_addr), 64'(s_addr[g]));
        if (g >= 0 && req_we[g]) chk({tag, "_wdata"}, 64'(ram_wdata), 64'(s_wdata[g]));
        chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(e.vld));
            if (e.vld != '0) chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(e.data));
        end
        if (g >= 0 && !req_we[g]) begin
            e.vld    = '0;
            e.vld[g] = 1'b1;
            e.data   = exp_mem[s_addr[g][7:0]];
            sb.push_back(e);
        end else begin
            sb.push_back('0);
        end
        if (g >= 0 && req_we[g]) begin
            for (int l = 0; l < SW; l++) begin
                if (s_wstrb[g][l]) exp_mem[s_addr[g][7:0]][l*8 +: 8] = s_wdata[g][l*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_word(i);
            exp_mem[i] = init_word(i);
        end

        // Reset with everything requesting, including a write
        req_valid  = '1;
        req_we[0]  = 1'b1;
        s_wstrb[0] = 4'hF;
        s_wdata[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < NR; i++) s_addr[i] = 16'h0040 + 16'(i);
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_wen", 64'(ram_write_en), 64'd0);
        chk("rst_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        @(posedge clk);
        #1;
        idle_all();
        rst_n = 1'b1;
        sb_restart();

        // Fairness: all reading single beats
        req_valid = '1;
        req_last  = '1;
        for (int i = 0; i < NR; i++) s_addr[i] = 16'h0040 + 16'(i);
        step("rr0", 4'b0001);
        step("rr1", 4'b0010);
        step("rr2", 4'b0100);
        step("rr3", 4'b1000);
        step("rr4", 4'b0001);
        idle_all();
        step("rr_drain", 4'b0000);

        // Single requester always valid -> granted every cycle
        req_valid[3] = 1'b1;
        req_last[3]  = 1'b1;
        s_addr[3]    = 16'h0047;
        step("solo0", 4'b1000);
        step("solo1", 4'b1000);
        step("solo2", 4'b1000);
        idle_all();
        step("solo_drain", 4'b0000);

        // Lock: req1 4-beat write burst, req0/req2 join after the lock is taken
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        s_wstrb[1]   = 4'hF;
        for (int b = 0; b < 4; b++) begin
            s_addr[1]   = 16'h0010 + 16'(b);
            s_wdata[1]  = 32'h1000_0000 + 32'(b);
            req_last[1] = (b == 3);
            step("lock_beat", 4'b0010);
            if (b == 0) begin
                req_valid[0] = 1'b1;
                req_last[0]  = 1'b1;
                s_addr[0]    = 16'h0012;
                req_valid[2] = 1'b1;
                req_last[2]  = 1'b1;
                s_addr[2]    = 16'h0013;
            end
        end
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b0;
        step("lock_next2", 4'b0100);
        req_valid[2] = 1'b0;
        step("lock_next0", 4'b0001);
        idle_all();
        step("lock_drain", 4'b0000);

        // Owner stall: req1 locked, idles 3 cycles while req0 waits
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        s_wstrb[1]   = 4'hF;
        s_addr[1]    = 16'h0030;
        s_wdata[1]   = 32'h3030_0001;
        req_valid[0] = 1'b1;
        req_last[0]  = 1'b1;
        s_addr[0]    = 16'h0010;
        step("stall_b1", 4'b0010);
        req_valid[1] = 1'b0;
        repeat (3) step("stall_gap", 4'b0000);
        req_valid[1] = 1'b1;
        req_last[1]  = 1'b1;
        s_addr[1]    = 16'h0031;
        s_wdata[1]   = 32'h3030_0002;
        step("stall_b2", 4'b0010);
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b0;
        step("stall_rel", 4'b0001);
        idle_all();
        step("stall_drain", 4'b0000);

        // Strobes: partial write, zero-strobe write, read both back
        req_valid[0] = 1'b1;
        req_last[0]  = 1'b1;
        req_we[0]    = 1'b1;
        s_addr[0]    = 16'h0020;
        s_wdata[0]   = 32'hAABB_CCDD;
        s_wstrb[0]   = 4'b0101;
        step("strb_wr", 4'b0001);
        req_we[0] = 1'b0;
        step("strb_rd", 4'b0001);
        req_we[0]  = 1'b1;
        s_addr[0]  = 16'h0021;
        s_wdata[0] = 32'hFFFF_FFFF;
        s_wstrb[0] = 4'b0000;
        step("strb0_wr", 4'b0001);
        req_we[0] = 1'b0;
        step("strb0_rd", 4'b0001);
        idle_all();
        step("strb_drain", 4'b0000);
        chk("strb_merge", 64'(exp_mem[8'h20]), 64'h0000_0000_C0BB_20DD);

        // Reset mid-burst with a read response pending
        req_valid[3] = 1'b1;
        s_addr[3]    = 16'h0050;
        step("mrst_b1", 4'b1000);
        s_addr[3] = 16'h0051;
        step("mrst_b2", 4'b1000);
        rst_n = 1'b0;
        idle_all();
        req_valid[0] = 1'b1;
        req_last[0]  = 1'b1;
        s_addr[0]    = 16'h0052;
        req_valid[3] = 1'b1;
        req_last[3]  = 1'b1;
        s_addr[3]    = 16'h0053;
        #1;
        chk("mrst_rsp", 64'(rsp_valid), 64'd0);
        chk("mrst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_restart();
        step("mrst_g0", 4'b0001);
        step("mrst_g3", 4'b1000);
        idle_all();
        step("mrst_drain", 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
